dp_sink_aux_responder: RTL and testbench

// Sink-side AUX channel responder for the DP sink model. It sits directly downstream
// of the source's AUX request output (AUX_IN_OUT / AUX_START_STOP) and produces the

---
 rtl/dp_sink_aux_responder.sv | 204 ++++++++++++++++++++
 tb/tb_dp_sink_aux_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_sink_aux_responder.sv
// rtl/dp_sink_aux_responder.sv - sink-side AUX request decoder and DPCD responder
module dp_sink_aux_responder #(
    parameter int         AUX_DATA_WIDTH = 8,
    parameter int         DPCD_DEPTH     = 512,
    parameter logic [7:0] MAX_LINK_RATE  = 8'h14,
    parameter logic [7:0] MAX_LANE_COUNT = 8'h04,
    parameter int         TURN_CYCLES    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AUX_DATA_WIDTH-1:0] aux_in_data,
    input  logic                      aux_start_stop,
    output logic [AUX_DATA_WIDTH-1:0] aux_out_data,
    output logic                      phy_start_stop,
    output logic [7:0]                link_bw_set,
    output logic [4:0]                lane_count_set,
    output logic [1:0]                tps_set,
    output logic                      req_dropped
);

    localparam int          AW      = $clog2(DPCD_DEPTH);
    localparam logic [20:0] DEPTH21 = 21'(DPCD_DEPTH);
    localparam logic [3:0]  CMD_WR  = 4'b1000;
    localparam logic [3:0]  CMD_RD  = 4'b1001;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_WDATA, S_TURN, S_REPLY} state_t;
    typedef enum logic [1:0] {R_ACK, R_READ, R_NACK, R_SHORT} rkind_t;

    // A one-cycle turnaround skips TURN entirely so the reply still lands on E+TURN_CYCLES.
    localparam state_t S_AFTER_REQ = (TURN_CYCLES == 1) ? S_REPLY : S_TURN;

    state_t                    r_state;
    state_t                    w_next_state;
    rkind_t                    r_kind;
    logic [3:0]                r_cmd;
    logic [19:0]               r_addr;
    logic [4:0]                r_len;
    logic [1:0]                r_hcnt;
    logic [4:0]                r_idx;
    logic                      r_nack;
    logic [4:0]                r_rlen;
    logic [4:0]                r_ridx;
    logic [15:0]               r_turn;
    logic                      r_wr_en;
    logic [AW-1:0]             r_wr_addr;
    logic [AUX_DATA_WIDTH-1:0] r_wr_data;
    logic                      r_drop;
    logic [7:0]                r_link_bw;
    logic [4:0]                r_lane_cnt;
    logic [1:0]                r_tps;
    logic [AUX_DATA_WIDTH-1:0] r_dpcd [DPCD_DEPTH];

    logic [4:0]  w_len_in;
    logic [20:0] w_req_end;
    logic        w_range_ok;
    logic        w_req_ok;
    logic [20:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;

    assign w_len_in   = {1'b0, aux_in_data[3:0]} + 5'd1;
    assign w_req_end  = {1'b0, r_addr} + {16'd0, w_len_in};
    assign w_range_ok = (w_req_end <= DEPTH21);
    assign w_req_ok   = w_range_ok && (r_cmd == CMD_WR || r_cmd == CMD_RD);
    assign w_wr_addr  = {1'b0, r_addr} + {16'd0, r_idx};
    // Reply byte 0 is the status, so payload byte k comes from addr+k-1.
    assign w_rd_addr  = r_addr[AW-1:0] + AW'(r_ridx) - AW'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state decode and reply byte/framing outputs.
    always_comb begin
        w_next_state   = r_state;
        phy_start_stop = 1'b0;
        aux_out_data   = '0;
        case (r_state)
            S_IDLE:  if (aux_start_stop) w_next_state = S_HDR;
            S_HDR: begin
                if (!aux_start_stop)
                    w_next_state = (r_hcnt == 2'd3) ? S_AFTER_REQ : S_IDLE;
                else if (r_hcnt == 2'd2 && r_cmd == CMD_WR && w_range_ok)
                    w_next_state = S_WDATA;
            end
            S_WDATA: if (!aux_start_stop) w_next_state = S_AFTER_REQ;
            S_TURN:  if (r_turn <= 16'd1) w_next_state = S_REPLY;
            S_REPLY: begin
                phy_start_stop = 1'b1;
                if (r_ridx == 5'd0)
                    aux_out_data = (r_kind == R_NACK || r_kind == R_SHORT) ?
                                   AUX_DATA_WIDTH'(8'h10) : '0;
                else if (r_kind == R_SHORT)
                    aux_out_data = AUX_DATA_WIDTH'(r_idx);
                else
                    aux_out_data = r_dpcd[w_rd_addr];
                if (r_ridx == r_rlen - 5'd1) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Header capture, write-data pipeline, reply selection and turnaround counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_kind    <= R_ACK;
            r_cmd     <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_hcnt    <= '0;
            r_idx     <= '0;
            r_nack    <= 1'b0;
            r_rlen    <= '0;
            r_ridx    <= '0;
            r_turn    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_drop  <= aux_start_stop && (r_state == S_TURN || r_state == S_REPLY);
            case (r_state)
                S_IDLE: if (aux_start_stop) begin
                    r_cmd         <= aux_in_data[7:4];
                    r_addr[19:16] <= aux_in_data[3:0];
                    r_hcnt        <= 2'd0;
                    r_idx         <= 5'd0;
                end
                S_HDR: begin
                    if (aux_start_stop) begin
                        case (r_hcnt)
                            2'd0:    r_addr[15:8] <= aux_in_data;
                            2'd1:    r_addr[7:0]  <= aux_in_data;
                            2'd2: begin
                                r_len  <= w_len_in;
                                r_nack <= !w_req_ok;
                            end
                            default: ;
                        endcase
                        if (r_hcnt != 2'd3) r_hcnt <= r_hcnt + 2'd1;
                    end else if (r_hcnt == 2'd3) begin
                        // Valid writes never stay here, so this is a read or a NACK.
                        r_kind <= (r_nack || r_cmd != CMD_RD) ? R_NACK : R_READ;
                        r_rlen <= (r_nack || r_cmd != CMD_RD) ? 5'd1 : r_len + 5'd1;
                        r_ridx <= 5'd0;
                        r_turn <= 16'(TURN_CYCLES - 1);
                    end
                end
                S_WDATA: begin
                    if (aux_start_stop) begin
                        if (r_idx < r_len) begin
                            // Read-only bytes are still counted toward the accepted total.
                            r_wr_en   <= (w_wr_addr >= 21'h00100);
                            r_wr_addr <= w_wr_addr[AW-1:0];
                            r_wr_data <= aux_in_data;
                            r_idx     <= r_idx + 5'd1;
                        end
                    end else begin
                        r_kind <= (r_idx < r_len) ? R_SHORT : R_ACK;
                        r_rlen <= (r_idx < r_len) ? 5'd2 : 5'd1;
                        r_ridx <= 5'd0;
                        r_turn <= 16'(TURN_CYCLES - 1);
                    end
                end
                S_TURN:  r_turn <= r_turn - 16'd1;
                S_REPLY: r_ridx <= r_ridx + 5'd1;
                default: ;
            endcase
        end
    end

    // DPCD storage with its power-on identity/capability bytes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DPCD_DEPTH; i++) r_dpcd[i] <= '0;
            r_dpcd[0] <= AUX_DATA_WIDTH'(8'h12);
            r_dpcd[1] <= AUX_DATA_WIDTH'(MAX_LINK_RATE);
            r_dpcd[2] <= AUX_DATA_WIDTH'(MAX_LANE_COUNT);
        end else if (r_wr_en) begin
            r_dpcd[r_wr_addr] <= r_wr_data;
        end
    end

    // Link-config mirrors of DPCD 0x100..0x102 for the PHY model.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_link_bw  <= '0;
            r_lane_cnt <= '0;
            r_tps      <= '0;
        end else begin
            r_link_bw  <= 8'(r_dpcd[AW'(256)]);
            r_lane_cnt <= r_dpcd[AW'(257)][4:0];
            r_tps      <= r_dpcd[AW'(258)][1:0];
        end
    end

    assign link_bw_set    = r_link_bw;
    assign lane_count_set = r_lane_cnt;
    assign tps_set        = r_tps;
    assign req_dropped    = r_drop;

endmodule

// File: tb/tb_dp_sink_aux_responder.sv
// tb/tb_dp_sink_aux_responder.sv - scoreboard bench for dp_sink_aux_responder
module tb_dp_sink_aux_responder;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] aux_in_data = 8'h00;
    logic       aux_start_stop = 1'b0;
    logic [7:0] aux_out_data;
    logic       phy_start_stop;
    logic [7:0] link_bw_set;
    logic [4:0] lane_count_set;
    logic [1:0] tps_set;
    logic       req_dropped;

    dp_sink_aux_responder #(.TURN_CYCLES(T)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .aux_in_data    (aux_in_data),
        .aux_start_stop (aux_start_stop),
        .aux_out_data   (aux_out_data),
        .phy_start_stop (phy_start_stop),
        .link_bw_set    (link_bw_set),
        .lane_count_set (lane_count_set),
        .tps_set        (tps_set),
        .req_dropped    (req_dropped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] b;
    } exp_t;

    exp_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    bit         saw_drop = 1'b0;
    logic [7:0] ref_mem [512];
    logic [7:0] req [32];
    int         nreq;

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every reply byte must match the head of the scoreboard in value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (req_dropped) saw_drop = 1'b1;
        if (phy_start_stop) begin
            if (exp_q.size() == 0) begin
                check("unexpected_reply_byte", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("reply_byte", int'(aux_out_data), int'(e.b));
                check("reply_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic ref_reset();
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
        ref_mem[0] = 8'h12;
        ref_mem[1] = 8'h14;
        ref_mem[2] = 8'h04;
    endtask

    task automatic check_link();
        check("link_bw_set", int'(link_bw_set), int'(ref_mem[256]));
        check("lane_count_set", int'(lane_count_set), int'(ref_mem[257][4:0]));
        check("tps_set", int'(tps_set), int'(ref_mem[258][1:0]));
    endtask

    // Model the request in req[0..nreq-1], drive it, and queue the expected reply.
    task automatic run_req(input bit drop_in_turn, input bit wait_done);
        logic [7:0] rep[$];
        logic [3:0] cmd;
        int addr, len, nd, p;
        rep.delete();
        if (nreq >= 4) begin
            cmd  = req[0][7:4];
            addr = int'({req[0][3:0], req[1], req[2]});
            len  = int'(req[3][3:0]) + 1;
            if ((cmd != 4'h8 && cmd != 4'h9) || addr + len > 512) begin
                rep.push_back(8'h10);
            end else if (cmd == 4'h9) begin
                rep.push_back(8'h00);
                for (int i = 0; i < len; i++) rep.push_back(ref_mem[addr + i]);
            end else begin
                nd = (nreq - 4 > len) ? len : nreq - 4;
                for (int i = 0; i < nd; i++)
                    if (addr + i >= 256) ref_mem[addr + i] = req[4 + i];
                if (nreq - 4 < len) begin
                    rep.push_back(8'h10);
                    rep.push_back(8'(nreq - 4));
                end else begin
                    rep.push_back(8'h00);
                end
            end
        end
        for (int i = 0; i < nreq; i++) begin
            @(posedge clk); #1;
            aux_start_stop = 1'b1;
            aux_in_data    = req[i];
        end
        @(posedge clk); #1;
        aux_start_stop = 1'b0;
        aux_in_data    = 8'h00;
        p = cyc;
        for (int k = 0; k < rep.size(); k++) exp_q.push_back('{p + T + k, rep[k]});
        if (drop_in_turn) begin
            @(posedge clk); #1;
            aux_start_stop = 1'b1;
            aux_in_data    = 8'hA5;
            @(posedge clk); #1;
            aux_start_stop = 1'b0;
            aux_in_data    = 8'h00;
        end
        if (wait_done) begin
            repeat (T + 26) @(posedge clk);
            #1;
            check("reply_drained", exp_q.size(), 0);
            check_link();
        end
    endtask

    task automatic set_hdr(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        req[0] = b0; req[1] = b1; req[2] = b2; req[3] = b3;
        nreq = 4;
    endtask

    initial begin
        int w, kind, sel, addr, len;
        logic [3:0] cmd;
        ref_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_phy_start_stop", int'(phy_start_stop), 0);
        check("rst_aux_out_data", int'(aux_out_data), 0);
        check("rst_req_dropped", int'(req_dropped), 0);
        check_link();

        // Capability read of 0x000..0x002.
        set_hdr(8'h90, 8'h00, 8'h00, 8'h02);
        run_req(1'b0, 1'b1);
        check("no_spurious_drop", int'(saw_drop), 0);

        // Link-config write.
        set_hdr(8'h80, 8'h01, 8'h00, 8'h01);
        req[4] = 8'h0A; req[5] = 8'h02; nreq = 6;
        run_req(1'b0, 1'b1);
        check("link_bw_0a", int'(link_bw_set), 8'h0A);
        check("lane_count_2", int'(lane_count_set), 2);

        // Read crossing the end of the implemented DPCD.
        set_hdr(8'h90, 8'h01, 8'hFF, 8'h01);
        run_req(1'b0, 1'b1);

        // Short write then read-back of the written region.
        set_hdr(8'h80, 8'h01, 8'h10, 8'h03);
        req[4] = 8'h11; req[5] = 8'h22; nreq = 6;
        run_req(1'b0, 1'b1);
        set_hdr(8'h90, 8'h01, 8'h10, 8'h03);
        run_req(1'b0, 1'b1);

        // Header cut after B1, then a normal read.
        req[0] = 8'h90; req[1] = 8'h00; nreq = 2;
        run_req(1'b0, 1'b1);
        set_hdr(8'h90, 8'h00, 8'h00, 8'h00);
        run_req(1'b0, 1'b1);

        // Write into the read-only area is ACKed but leaves the byte unchanged.
        set_hdr(8'h80, 8'h00, 8'h03, 8'h00);
        req[4] = 8'h5A; nreq = 5;
        run_req(1'b0, 1'b1);
        set_hdr(8'h90, 8'h00, 8'h03, 8'h00);
        run_req(1'b0, 1'b1);

        // Request byte during turnaround: dropped flag, reply unaffected.
        saw_drop = 1'b0;
        set_hdr(8'h90, 8'h00, 8'h00, 8'h01);
        run_req(1'b1, 1'b1);
        check("req_dropped_seen", int'(saw_drop), 1);

        // Randomized mix.
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 5);
            sel  = $urandom_range(0, 3);
            case (sel)
                0:       addr = $urandom_range(0, 511);
                1:       addr = $urandom_range(248, 264);
                2:       addr = $urandom_range(496, 511);
                default: addr = $urandom_range(0, 20'hFFFFF);
            endcase
            len = $urandom_range(1, 16);
            cmd = (kind < 2) ? 4'h9 : 4'h8;
            if (kind == 5) begin
                cmd = 4'($urandom_range(0, 15));
                if (cmd == 4'h8 || cmd == 4'h9) cmd = 4'hA;
            end
            set_hdr({cmd, 4'(addr >> 16)}, 8'(addr >> 8), 8'(addr), 8'(len - 1));
            if (kind == 2 || kind == 3) nreq = 4 + len + $urandom_range(0, 2);
            else if (kind == 4)         nreq = 4 + $urandom_range(0, len - 1);
            else if (kind == 5 && $urandom_range(0, 1) == 1) nreq = $urandom_range(1, 3);
            for (int i = 4; i < nreq; i++) req[i] = 8'($urandom_range(0, 255));
            run_req(1'b0, 1'b1);
        end

        // Reset while a long reply is in flight.
        set_hdr(8'h90, 8'h00, 8'h00, 8'h0F);
        run_req(1'b0, 1'b0);
        w = 0;
        while (!phy_start_stop && w < 30) begin
            @(posedge clk); #1;
            w++;
        end
        check("reset_reply_started", int'(phy_start_stop), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        ref_reset();
        check("reset_phy_low", int'(phy_start_stop), 0);
        repeat (T + 20) @(posedge clk);
        #1;
        check("reset_no_reply", exp_q.size(), 0);
        set_hdr(8'h90, 8'h01, 8'h00, 8'h02);
        run_req(1'b0, 1'b1);
        set_hdr(8'h90, 8'h00, 8'h00, 8'h02);
        run_req(1'b0, 1'b1);

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
